// File: rtl/rr_arbiter16_pkg.sv
// Shared definitions for the 16-way round-robin arbiter: requester count,
// FSM state encoding and the enable-gated 2-to-4 decode stage.
package rr_arbiter16_pkg;

  localparam int NREQ = 16;
  localparam int IDW  = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [3:0] dec2to4(input logic en, input logic [1:0] sel);
    logic [3:0] y;
    y = 4'b0000;
    if (en) y[sel] = 1'b1;
    return y;
  endfunction

endpackage

// File: rtl/rr_arbiter16_dec4to16_en.sv
// Enable-gated 4-to-16 one-hot decoder: one 2-to-4 row stage on sel[3:2]
// whose outputs enable four 2-to-4 column stages on sel[1:0].
module dec4to16_en
  import rr_arbiter16_pkg::*;
(
  input  logic            en_i,
  input  logic [IDW-1:0]  sel_i,
  output logic [NREQ-1:0] dec_o
);

  logic [3:0] row_en;

  assign row_en = dec2to4(en_i, sel_i[3:2]);

  for (genvar g = 0; g < 4; g++) begin : g_col
    assign dec_o[4*g +: 4] = dec2to4(row_en[g], sel_i[1:0]);
  end

endmodule

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter for 16 requesters with a hold limit; the registered
// winner index is decoded to a one-hot grant gated by grant-valid.
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter  int MAX_HOLD = 8,
  localparam int HCW      = $clog2(MAX_HOLD)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id,
  output logic            gnt_valid,
  output logic            busy
);

  localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);

  state_e           state_q, state_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [HCW-1:0]   hold_q, hold_d;
  logic [IDW-1:0]   ptr_q, ptr_d;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [IDW-1:0]    ffs;
  logic [IDW-1:0]    winner;
  logic              owner_req;
  logic              others_req;

  // Rotate so that bit ptr lands at position 0, then find-first-set; the
  // offset added back to ptr wraps naturally in 4 bits.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so
    // no path leaves it unassigned, which would infer a latch.
    req_dbl = {req, req} >> ptr_q;
    req_rot = req_dbl[NREQ-1:0];
    ffs     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_rot[i]) ffs = IDW'(i);
    end
    winner = ptr_q + ffs;
  end

  // In GRANT the decoded grant is exactly the owner's one-hot mask.
  assign owner_req  = |(req & gnt);
  assign others_req = |(req & ~gnt);

  always_comb begin
    state_d  = state_q;
    gnt_id_d = gnt_id_q;
    hold_d   = hold_q;
    ptr_d    = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d  = ST_GRANT;
          gnt_id_d = winner;
          hold_d   = '0;
        end
      end
      ST_GRANT: begin
        if (!owner_req || (hold_q == HOLD_LAST && others_req)) begin
          state_d = ST_IDLE;
          ptr_d   = gnt_id_q + IDW'(1);
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HCW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_id_q <= IDW'(NREQ - 1);
      hold_q   <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_id_q <= gnt_id_d;
      hold_q   <= hold_d;
      ptr_q    <= ptr_d;
    end
  end

  assign gnt_valid = (state_q == ST_GRANT);
  assign gnt_id    = gnt_id_q;
  assign busy      = gnt_valid | (|req);

  dec4to16_en u_dec (
    .en_i  (gnt_valid),
    .sel_i (gnt_id_q),
    .dec_o (gnt)
  );

endmodule

// File: tb/tb_rr_arbiter16.sv
// Self-checking bench for rr_arbiter16: directed scenarios plus random
// requests, compared against a queue-fed reference model of the arbitration rules.
module tb_rr_arbiter16;

  localparam int MAX_HOLD = 8;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [15:0] gnt;
  logic [3:0]  gnt_id;
  logic        gnt_valid;
  logic        busy;

  rr_arbiter16 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: owner/hold/pointer tracked as plain integers.
  typedef struct packed {
    logic [15:0] gnt;
    logic [3:0]  id;
    logic        valid;
  } exp_t;

  exp_t exp_q[$];

  bit m_valid = 1'b0;
  int m_id    = 15;
  int m_ptr   = 0;
  int m_held  = 0;

  always @(posedge clk) begin
    exp_t e;
    logic [15:0] others;
    bit found;
    if (rst) begin
      m_valid = 1'b0;
      m_id    = 15;
      m_ptr   = 0;
      m_held  = 0;
    end else if (!m_valid) begin
      found = 1'b0;
      for (int k = 0; k < 16; k++) begin
        int idx;
        idx = (m_ptr + k) % 16;
        if (!found && req[idx]) begin
          found  = 1'b1;
          m_id   = idx;
        end
      end
      if (found) begin
        m_valid = 1'b1;
        m_held  = 0;
      end
    end else begin
      others = req;
      others[m_id] = 1'b0;
      if (!req[m_id] || (m_held == MAX_HOLD - 1 && others != 16'h0)) begin
        m_valid = 1'b0;
        m_ptr   = (m_id + 1) % 16;
      end else if (m_held < MAX_HOLD - 1) begin
        m_held++;
      end
    end
    e.valid = m_valid;
    e.id    = 4'(m_id);
    e.gnt   = m_valid ? (16'h0001 << m_id) : 16'h0000;
    exp_q.push_back(e);
  end

  // Monitor: pops one expectation per clock and compares away from the edge.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty actual=0 expected=1 entries at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      check("sb_gnt", 32'(gnt), 32'(e.gnt));
      check("sb_gnt_id", 32'(gnt_id), 32'(e.id));
      check("sb_gnt_valid", 32'(gnt_valid), 32'(e.valid));
      check("sb_busy", 32'(busy), 32'(e.valid | (|req)));
      check("sb_onehot", 32'($countones(gnt) <= 1), 32'd1);
    end
  end

  // Apply inputs at the falling edge, then return just after the next rising edge.
  task automatic step(input logic [15:0] r, input logic rs);
    @(negedge clk);
    req = r;
    rst = rs;
    @(posedge clk);
    #3;
  endtask

  logic [15:0] live;
  logic [31:0] flip;

  initial begin
    rst = 1'b1;
    req = 16'h0000;

    // Reset holds everything off even with all requests high.
    repeat (2) begin
      step(16'hFFFF, 1'b1);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_id", 32'(gnt_id), 32'd15);
      check("rst_valid", 32'(gnt_valid), 32'd0);
    end
    step(16'hFFFF, 1'b0);
    check("first_grant", 32'(gnt), 32'h0001);

    // Single requester 5.
    step(16'h0000, 1'b1);
    step(16'h0000, 1'b0);
    check("idle_gnt", 32'(gnt), 32'h0);
    step(16'h0020, 1'b0);
    check("single_gnt", 32'(gnt), 32'h0020);
    check("single_id", 32'(gnt_id), 32'd5);
    repeat (3) step(16'h0020, 1'b0);
    check("single_hold", 32'(gnt), 32'h0020);
    step(16'h0000, 1'b0);
    check("single_drop", 32'(gnt), 32'h0);
    check("single_id_kept", 32'(gnt_id), 32'd5);

    // Rotation between 2 and 8, each dropping after two grant cycles.
    step(16'h0000, 1'b1);
    step(16'h0104, 1'b0); check("rot_a", 32'(gnt_id), 32'd2);
    step(16'h0104, 1'b0);
    step(16'h0100, 1'b0); check("rot_gap1", 32'(gnt), 32'h0);
    step(16'h0104, 1'b0); check("rot_b", 32'(gnt_id), 32'd8);
    step(16'h0104, 1'b0);
    step(16'h0004, 1'b0); check("rot_gap2", 32'(gnt), 32'h0);
    step(16'h0104, 1'b0); check("rot_c", 32'(gnt_id), 32'd2);
    step(16'h0104, 1'b0);
    step(16'h0100, 1'b0); check("rot_gap3", 32'(gnt), 32'h0);
    step(16'h0104, 1'b0); check("rot_d", 32'(gnt_id), 32'd8);

    // Wrap-around after requester 15 releases.
    step(16'h0000, 1'b1);
    step(16'h8000, 1'b0); check("wrap_15", 32'(gnt), 32'h8000);
    step(16'h0000, 1'b0);
    step(16'h4001, 1'b0); check("wrap_0", 32'(gnt), 32'h0001);
    step(16'h0000, 1'b0);

    // Hold limit with requesters 3 and 5 both continuous.
    step(16'h0000, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(16'h0028, 1'b0); check("hold_3", 32'(gnt), 32'h0008);
    end
    step(16'h0028, 1'b0); check("hold_gap1", 32'(gnt), 32'h0);
    for (int i = 0; i < 8; i++) begin
      step(16'h0028, 1'b0); check("hold_5", 32'(gnt), 32'h0020);
    end
    step(16'h0028, 1'b0); check("hold_gap2", 32'(gnt), 32'h0);
    step(16'h0028, 1'b0); check("hold_3_again", 32'(gnt), 32'h0008);
    repeat (25) step(16'h0008, 1'b0);
    check("sole_holder", 32'(gnt), 32'h0008);
    step(16'h0028, 1'b0); check("late_competitor", 32'(gnt), 32'h0);

    // Reset in the middle of a grant to requester 9.
    step(16'h0000, 1'b1);
    step(16'h0200, 1'b0); check("mid_grant", 32'(gnt_id), 32'd9);
    step(16'h0200, 1'b0);
    step(16'h0200, 1'b1); check("mid_rst_gnt", 32'(gnt), 32'h0);
    check("mid_rst_id", 32'(gnt_id), 32'd15);
    step(16'h0200, 1'b0); check("regrant_9", 32'(gnt), 32'h0200);

    // Random level-sensitive requests with occasional resets.
    live = 16'h0000;
    for (int n = 0; n < 1500; n++) begin
      flip = $urandom & $urandom & $urandom;
      live = live ^ flip[15:0];
      step(live, ($urandom_range(0, 199) == 0));
    end

    step(16'h0000, 1'b0);
    step(16'h0000, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter16.md
Name: rr_arbiter16

Overview:
- Round-robin arbiter that shares one resource between 16 requesters and drives a one-hot grant vector.
- The winning 4-bit index is registered, then expanded to one-hot by a 4-to-16 decoder gated by grant-valid.
- Sits in front of any shared datapath that the 16 clients address by decoded select line.
- A hold-limit counter stops one requester from monopolising the resource while others wait.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles before forced rotation when another request is pending; legal range 2..256.
- HCW, $clog2(MAX_HOLD): hold-counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req  input  16  request vector; bit i = requester i; level-sensitive, held high while the resource is wanted
- gnt  output  16  one-hot grant; all zero when no grant is active
- gnt_id  output  4  index of the current/last grantee
- gnt_valid  output  1  high while a grant is active
- busy  output  1  high when a grant is active or any req bit is high

Behaviour:
- Reset: one synchronous edge with rst=1 forces the following.
  - state=IDLE, gnt=0, gnt_id=4'd15 (so requester 0 has first priority), gnt_valid=0, hold_cnt=0, ptr=0.
  - rst overrides all other inputs, including mid-grant; gnt drops in the cycle after the rst edge.
- FSM has two states, IDLE and GRANT.
- IDLE:
  - If req!=0, select the first i with req[i]=1, searching ptr, ptr+1, ... 15, 0, ... ptr-1 (mod 16).
  - Register gnt_id=i, gnt_valid=1, hold_cnt=0 and go to GRANT.
  - Latency: req sampled at edge t, so gnt is visible after edge t, i.e. in cycle t+1.
  - If req==0, stay in IDLE; gnt_id keeps its last value.
- GRANT, with owner = gnt_id:
  - Release when req[owner]==0 at an edge.
  - Also release when hold_cnt==MAX_HOLD-1 and (req with bit owner masked)!=0.
  - On release: gnt_valid=0, ptr=owner+1 mod 16 (15 wraps to 0), state goes to IDLE.
  - Exactly one idle cycle separates consecutive grants; there is no back-to-back grant hand-over.
  - Otherwise: stay in GRANT; hold_cnt increments and saturates at MAX_HOLD-1.
  - A sole requester keeps the grant indefinitely. If a competitor arrives after saturation, release happens at the next edge.
- gnt is produced by decoding gnt_id with enable=gnt_valid, so it is combinational from registers only.
  - Glitch-free relative to req.
  - popcount(gnt) is at most 1 at all times.
- busy = gnt_valid | (|req), combinational.
- Simultaneous events:
  - Owner drops req in the same cycle the hold limit is hit: treat as a normal release; ptr update is identical.
  - New requests arriving during GRANT are not seen until the IDLE cycle. The arbiter re-selects from the req vector sampled in that IDLE cycle.
- A requester must not treat gnt as held after it lowers req. The grant is removed one cycle after req falls.

Decomposition:
- Shared package/header: state encodings (ST_IDLE=1'b0, ST_GRANT=1'b1) and NREQ=16.
- Natural sub-module: dec4to16_en.
  - Enable-gated 4-to-16 one-hot decoder, output bit i high iff en && sel==i.
  - Built from five enable-gated 2-to-4 stages, matching the team's existing decoder structure.
- Priority rotation is a rotate-mask plus find-first-set, coded inline in rr_arbiter16.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with req=16'hFFFF -> gnt=0, gnt_valid=0, gnt_id=15 throughout. After rst falls, next edge grants bit 0 (gnt=16'h0001).
- Single request: req=16'h0020 at edge t -> gnt=16'h0020, gnt_id=5 from cycle t+1. Drop req at edge t+4 -> gnt=0 in cycle t+5.
- Rotation with simultaneous requests: req=16'h0104 held, each requester dropping after 2 grant cycles -> grant order 2, 8, 2, 8, with one gnt=0 cycle between each.
- Wrap-around: after a grant to 15 releases, req=16'h4001 -> next grant is 0, not 14.
- Hold limit: MAX_HOLD=8, req=16'h0028 continuous -> requester 3 holds exactly 8 cycles, 1 idle cycle, requester 5 holds 8 cycles, then 3 again. Sole requester 3 alone stays granted for more than 20 cycles.
- Reset mid-grant: assert rst during requester 9's grant -> gnt=0 the next cycle. After release with req=16'h0200 held, 9 is re-granted and ptr starts at 0.
